mod_swapchain: RTL



---
 rtl/mod_swapchain_pkg.sv | 11 +
 rtl/mod_swapchain_if.sv | 13 +
 rtl/mod_swapchain_wrap_detect.sv | 12 +
 rtl/mod_swapchain.sv | 101 ++++++++++
 4 files changed

// File: rtl/mod_swapchain_pkg.sv
// settings: shared modulation settings record, swap-chain state encoding and constants
package settings;
    localparam logic [31:0] REP_INFINITE = 32'hFFFF_FFFF;
    typedef struct packed {
        logic        REQ_RD_SEGMENT;
        logic [14:0] CYCLE_0;
        logic [14:0] CYCLE_1;
        logic [31:0] REP;
    } mod_settings_t;
    typedef enum logic [1:0] {INFINITE, WAIT_START, FINITE, STOPPED} swapchain_state_t;
endpackage

// File: rtl/mod_swapchain_if.sv
// mod_swapchain_if: settings, segment indices and playback outputs of the swap controller
interface mod_swapchain_if;
    import settings::*;
    logic          UPDATE_SETTINGS;
    mod_settings_t MOD_SETTINGS;
    logic [14:0]   IDX_0;
    logic [14:0]   IDX_1;
    logic          SEGMENT;
    logic [14:0]   IDX;
    logic          STOP;
    modport master (output UPDATE_SETTINGS, MOD_SETTINGS, IDX_0, IDX_1, input SEGMENT, IDX, STOP);
    modport slave (input UPDATE_SETTINGS, MOD_SETTINGS, IDX_0, IDX_1, output SEGMENT, IDX, STOP);
endinterface

// File: rtl/mod_swapchain_wrap_detect.sv
// mod_wrap_detect: one-cycle pulse when a sample index falls back to 0 from a nonzero value
module mod_wrap_detect (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [14:0] IDX,
    output logic        WRAP
);
    logic [14:0] prev_q, prev_d;
    always_comb prev_d = IDX;
    always_ff @(posedge CLK) prev_q <= !RST_N ? '0 : prev_d;
    assign WRAP = (IDX == '0) && (prev_q != '0);
endmodule

// File: rtl/mod_swapchain.sv
// mod_swapchain: picks the played segment, counts finite loops and raises STOP when done
module mod_swapchain
    import settings::*;
(
    input logic            CLK,
    input logic            RST_N,
    mod_swapchain_if.slave bus
);
    swapchain_state_t state_q, state_d;
    logic        seg_q, seg_d, stop_q, stop_d, req_seg_q, req_seg_d;
    logic [14:0] idx_q, idx_d, cycle_q, cycle_d;
    logic [31:0] loop_q, loop_d, rep_q, rep_d;
    logic        wrap_0, wrap_1;
    mod_wrap_detect u_wrap_0 (.CLK(CLK), .RST_N(RST_N), .IDX(bus.IDX_0), .WRAP(wrap_0));
    mod_wrap_detect u_wrap_1 (.CLK(CLK), .RST_N(RST_N), .IDX(bus.IDX_1), .WRAP(wrap_1));
    mod_settings_t ms;
    logic [14:0] idx_cur, idx_new, cycle_new;
    logic        wrap_cur, wrap_req;
    assign ms        = bus.MOD_SETTINGS;
    assign idx_cur   = seg_q ? bus.IDX_1 : bus.IDX_0;
    assign idx_new   = ms.REQ_RD_SEGMENT ? bus.IDX_1 : bus.IDX_0;
    assign cycle_new = ms.REQ_RD_SEGMENT ? ms.CYCLE_1 : ms.CYCLE_0;
    assign wrap_cur  = seg_q ? wrap_1 : wrap_0;
    assign wrap_req  = req_seg_q ? wrap_1 : wrap_0;
    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        idx_d     = idx_q;
        stop_d    = stop_q;
        loop_d    = loop_q;
        req_seg_d = req_seg_q;
        rep_d     = rep_q;
        cycle_d   = cycle_q;
        // An update always takes priority over any wrap or stop seen in the same cycle
        if (bus.UPDATE_SETTINGS) begin
            req_seg_d = ms.REQ_RD_SEGMENT;
            rep_d     = ms.REP;
            cycle_d   = cycle_new;
            stop_d    = 1'b0;
            if (ms.REP == REP_INFINITE) begin
                seg_d   = ms.REQ_RD_SEGMENT;
                idx_d   = idx_new;
                state_d = INFINITE;
            end else if (cycle_new == '0) begin
                seg_d   = ms.REQ_RD_SEGMENT;
                idx_d   = '0;
                stop_d  = 1'b1;
                state_d = STOPPED;
            end else begin
                idx_d   = idx_cur;
                state_d = WAIT_START;
            end
        end else begin
            case (state_q)
                INFINITE: idx_d = idx_cur;
                WAIT_START: begin
                    idx_d = wrap_req ? '0 : idx_cur;
                    if (wrap_req) begin
                        seg_d   = req_seg_q;
                        loop_d  = '0;
                        state_d = FINITE;
                    end
                end
                FINITE: begin
                    idx_d  = idx_cur;
                    loop_d = wrap_cur ? loop_q + 32'd1 : loop_q;
                    if (loop_q == rep_q && idx_cur == cycle_q) begin
                        idx_d   = cycle_q;
                        stop_d  = 1'b1;
                        state_d = STOPPED;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= INFINITE;
            seg_q     <= 1'b0;
            idx_q     <= '0;
            stop_q    <= 1'b0;
            loop_q    <= '0;
            req_seg_q <= 1'b0;
            rep_q     <= REP_INFINITE;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            idx_q     <= idx_d;
            stop_q    <= stop_d;
            loop_q    <= loop_d;
            req_seg_q <= req_seg_d;
            rep_q     <= rep_d;
            cycle_q   <= cycle_d;
        end
    end
    assign bus.SEGMENT = seg_q;
    assign bus.IDX     = idx_q;
    assign bus.STOP    = stop_q;
endmodule
